// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multi-cycle RV32I core. It sequences each instruction
// through fetch, decode, execute, memory and writeback, and drives the
// datapath mux selects and write enables. One ALU and one unified memory
// port are shared across all of these steps.
//
// Memory handshake (valid/ready): the controller raises Mem_Rd or Mem_Wr and
// holds it, with the address select unchanged, until Mem_Ready is seen high
// on a rising edge. That edge completes the access, so it is committed once.
// With MEM_HANDSHAKE=0, Mem_Ready is ignored and every access takes one cycle.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   Instruction         IR contents, valid from DECODE onwards
//   Zero, Lt, Ltu       ALU compare flags used by BRANCH
//   Mem_Ready           memory completes the current access this cycle
//   PC_Wr, IR_Wr, Reg_Wr, Mem_Wr, Mem_Rd   enables/strobes
//   Adr_Src             0 = PC, 1 = ALUOut drives the memory address
//   ALU_Src1/ALU_Src2   ALU operand selects
//   Result_Src          writeback/PC source select
//   ALU_op              0000 ADD, 1000 SUB, else {Funct7b5, Funct3}
//   Imm_Ctrl            immediate format (I/S/B/U/J)
//   dWidth_ctrl         load/store width (Funct3 in memory states)
//   Illegal             high while trapped
//   Retire, Retired     completion pulse and retired-instruction count
//   state_dbg_o         current FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instruction,
    input  logic             Zero,
    input  logic             Lt,
    input  logic             Ltu,
    input  logic             Mem_Ready,
    output logic             PC_Wr,
    output logic             IR_Wr,
    output logic             Reg_Wr,
    output logic             Mem_Wr,
    output logic             Mem_Rd,
    output logic             Adr_Src,
    output logic [1:0]       ALU_Src1,
    output logic [1:0]       ALU_Src2,
    output logic [1:0]       Result_Src,
    output logic [3:0]       ALU_op,
    output logic [2:0]       Imm_Ctrl,
    output logic [2:0]       dWidth_ctrl,
    output logic             Illegal,
    output logic             Retire,
    output logic [CNT_W-1:0] Retired,
    output logic [3:0]       state_dbg_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       mem_rdy;
    logic       br_taken;
    logic [2:0] imm_dec;
    logic       unused_bits;

    assign opcode      = Instruction[6:0];
    assign funct3      = Instruction[14:12];
    assign funct7b5    = Instruction[30];
    assign mem_rdy     = MEM_HANDSHAKE ? Mem_Ready : 1'b1;
    assign unused_bits = ^{Instruction[31], Instruction[29:15], Instruction[11:7]};

    // Branch condition; 010/011 are not branch encodings and trap instead.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = Lt;
            3'b101:  br_taken = !Lt;
            3'b110:  br_taken = Ltu;
            3'b111:  br_taken = !Ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Immediate format follows the opcode; R-type and illegal opcodes
    // leave it at the I format since the immediate is unused there.
    always_comb begin
        imm_dec = 3'b000;
        case (opcode)
            OP_STORE:          imm_dec = 3'b001;
            OP_BRANCH:         imm_dec = 3'b010;
            OP_LUI, OP_AUIPC:  imm_dec = 3'b011;
            OP_JAL:            imm_dec = 3'b100;
            default:           imm_dec = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PC_Wr       = 1'b0;
        IR_Wr       = 1'b0;
        Reg_Wr      = 1'b0;
        Mem_Wr      = 1'b0;
        Mem_Rd      = 1'b0;
        Adr_Src     = 1'b0;
        ALU_Src1    = 2'b00;
        ALU_Src2    = 2'b00;
        Result_Src  = 2'b00;
        ALU_op      = 4'b0000;
        Imm_Ctrl    = (state_q == S_FETCH) ? 3'b000 : imm_dec;
        dWidth_ctrl = 3'b010;
        Illegal     = 1'b0;
        Retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                Mem_Rd     = 1'b1;
                ALU_Src2   = 2'b10;
                Result_Src = 2'b10;
                if (mem_rdy) begin
                    IR_Wr   = 1'b1;
                    PC_Wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute branch/JAL target (OldPC + imm) into ALUOut.
                ALU_Src1 = 2'b01;
                ALU_Src2 = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALU_Src1 = 2'b10;
                ALU_Src2 = 2'b01;
                // opcode bit 5 separates store (0100011) from load (0000011)
                state_d  = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                Adr_Src     = 1'b1;
                Mem_Rd      = 1'b1;
                dWidth_ctrl = funct3;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                Result_Src  = 2'b01;
                Reg_Wr      = 1'b1;
                dWidth_ctrl = funct3;
                Retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                Adr_Src     = 1'b1;
                Mem_Wr      = 1'b1;
                dWidth_ctrl = funct3;
                if (mem_rdy) begin
                    Retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALU_Src1 = 2'b10;
                ALU_op   = {funct7b5, funct3};
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                // Only shifts-right use bit 30 (SRAI); elsewhere it is imm data.
                ALU_Src1 = 2'b10;
                ALU_Src2 = 2'b01;
                ALU_op   = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                Reg_Wr  = 1'b1;
                Retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALU_Src1 = 2'b10;
                ALU_op   = 4'b1000;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    state_d = S_TRAP;
                end else begin
                    PC_Wr   = br_taken;
                    Retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_JAL: begin
                // PC <- ALUOut (target) while the ALU forms the link OldPC + 4.
                PC_Wr    = 1'b1;
                ALU_Src1 = 2'b01;
                ALU_Src2 = 2'b10;
                state_d  = S_ALUWB;
            end
            S_JALR: begin
                ALU_Src1 = 2'b10;
                ALU_Src2 = 2'b01;
                state_d  = (funct3 == 3'b000) ? S_JAL : S_TRAP;
            end
            S_UPPER: begin
                // opcode bit 5 separates LUI (0110111) from AUIPC (0010111)
                ALU_Src1 = opcode[5] ? 2'b11 : 2'b01;
                ALU_Src2 = 2'b01;
                state_d  = S_ALUWB;
            end
            S_TRAP: begin
                Illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign retired_d   = Retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    assign Retired     = retired_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (CNT_W=4 so the counter wrap is
// reachable). Each instruction is run from FETCH back to FETCH while a
// per-cycle snapshot of the outputs is recorded; checks then index into it.
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_UPPER    = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   Instruction;
    logic          Zero, Lt, Ltu, Mem_Ready;
    logic          PC_Wr, IR_Wr, Reg_Wr, Mem_Wr, Mem_Rd, Adr_Src;
    logic [1:0]    ALU_Src1, ALU_Src2, Result_Src;
    logic [3:0]    ALU_op;
    logic [2:0]    Imm_Ctrl, dWidth_ctrl;
    logic          Illegal, Retire;
    logic [CW-1:0] Retired;
    logic [3:0]    state_dbg;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, adr_src, retire, illegal;
        logic [1:0] src1, src2, rsrc;
        logic [3:0] aluop;
        logic [2:0] imm, dw;
    } snap_t;

    snap_t sn [0:39];
    int    ncyc;
    int    total = 0;
    int    bad   = 0;
    int    pulses;
    int    regwr_n;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .Mem_Ready(Mem_Ready),
        .PC_Wr(PC_Wr), .IR_Wr(IR_Wr), .Reg_Wr(Reg_Wr), .Mem_Wr(Mem_Wr),
        .Mem_Rd(Mem_Rd), .Adr_Src(Adr_Src), .ALU_Src1(ALU_Src1),
        .ALU_Src2(ALU_Src2), .Result_Src(Result_Src), .ALU_op(ALU_op),
        .Imm_Ctrl(Imm_Ctrl), .dWidth_ctrl(dWidth_ctrl), .Illegal(Illegal),
        .Retire(Retire), .Retired(Retired), .state_dbg_o(state_dbg)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        Mem_Ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    function automatic snap_t capture();
        snap_t s;
        s.st = state_dbg;   s.pc_wr = PC_Wr;   s.ir_wr = IR_Wr;
        s.reg_wr = Reg_Wr;  s.mem_wr = Mem_Wr; s.mem_rd = Mem_Rd;
        s.adr_src = Adr_Src; s.retire = Retire; s.illegal = Illegal;
        s.src1 = ALU_Src1;  s.src2 = ALU_Src2; s.rsrc = Result_Src;
        s.aluop = ALU_op;   s.imm = Imm_Ctrl;  s.dw = dWidth_ctrl;
        return s;
    endfunction

    // ---- driver: run one instruction, Mem_Ready low for cycles lo_from..lo_to ----
    task automatic run_instr(input logic [31:0] ins, input int lo_from, input int lo_to);
        Instruction = ins;
        ncyc = 0;
        pulses = 0;
        regwr_n = 0;
        for (int c = 0; c < 40; c++) begin
            Mem_Ready = !(c >= lo_from && c <= lo_to);
            #1;
            sn[c] = capture();
            ncyc = c + 1;
            if (sn[c].retire) pulses++;
            if (sn[c].reg_wr) regwr_n++;
            @(posedge clk); #1;
            if ((sn[c].st != S_FETCH && state_dbg == S_FETCH) || state_dbg == S_TRAP) break;
        end
        Mem_Ready = 1'b1;
    endtask

    int retire_total;

    initial begin
        rst_n = 1'b1; Instruction = 32'h0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; Mem_Ready = 1'b0;
        @(posedge clk); #1;

        // ---- reset state ----
        do_reset();
        chk("rst_state", state_dbg, S_FETCH);
        chk("rst_retired", Retired, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_mem_rd", Mem_Rd, 1);
        chk("rst_ir_wr", IR_Wr, 0);
        chk("rst_pc_wr", PC_Wr, 0);

        // ---- add x3,x1,x2 ----
        run_instr(32'h002081B3, -1, -1);
        chk("add_cycles", ncyc, 4);
        chk("add_st0", sn[0].st, S_FETCH);
        chk("add_st1", sn[1].st, S_DECODE);
        chk("add_st2", sn[2].st, S_EXECR);
        chk("add_st3", sn[3].st, S_ALUWB);
        chk("add_irwr", sn[0].ir_wr, 1);
        chk("add_aluop", sn[2].aluop, 4'b0000);
        chk("add_regwr_c4", sn[3].reg_wr, 1);
        chk("add_regwr_n", regwr_n, 1);
        chk("add_retired", Retired, 1);

        // ---- lw with two wait cycles in MEMREAD ----
        run_instr(32'h0000A183, 3, 4);
        chk("lw_cycles", ncyc, 7);
        chk("lw_st2", sn[2].st, S_MEMADR);
        chk("lw_st4", sn[4].st, S_MEMREAD);
        chk("lw_adr_src", sn[3].adr_src, 1);
        chk("lw_mem_rd", sn[5].mem_rd, 1);
        chk("lw_st6", sn[6].st, S_MEMWB);
        chk("lw_rsrc", sn[6].rsrc, 2'b01);
        chk("lw_regwr", sn[6].reg_wr, 1);
        chk("lw_regwr_n", regwr_n, 1);
        chk("lw_dw", sn[6].dw, 3'b010);
        chk("lw_retired", Retired, 2);

        // ---- bne taken / not taken ----
        Zero = 1'b0;
        run_instr(32'h00209463, -1, -1);
        chk("bne_t_cycles", ncyc, 3);
        chk("bne_t_st", sn[2].st, S_BRANCH);
        chk("bne_t_pcwr", sn[2].pc_wr, 1);
        chk("bne_t_aluop", sn[2].aluop, 4'b1000);
        chk("bne_t_imm", sn[2].imm, 3'b010);
        chk("bne_t_retire", sn[2].retire, 1);
        Zero = 1'b1;
        run_instr(32'h00209463, -1, -1);
        chk("bne_n_cycles", ncyc, 3);
        chk("bne_n_pcwr", sn[2].pc_wr, 0);
        chk("bne_retired", Retired, 4);
        Zero = 1'b0;

        // ---- srai / sub ----
        run_instr(32'h4020D193, -1, -1);
        chk("srai_cycles", ncyc, 4);
        chk("srai_st", sn[2].st, S_EXECI);
        chk("srai_aluop", sn[2].aluop, 4'b1101);
        run_instr(32'h402081B3, -1, -1);
        chk("sub_aluop", sn[2].aluop, 4'b1000);
        chk("sub_retired", Retired, 6);

        // ---- sw with one wait cycle in MEMWRITE ----
        run_instr(32'h0020A023, 3, 3);
        chk("sw_cycles", ncyc, 5);
        chk("sw_st3", sn[3].st, S_MEMWRITE);
        chk("sw_memwr3", sn[3].mem_wr, 1);
        chk("sw_retire3", sn[3].retire, 0);
        chk("sw_memwr4", sn[4].mem_wr, 1);
        chk("sw_retire4", sn[4].retire, 1);
        chk("sw_imm", sn[3].imm, 3'b001);
        chk("sw_regwr_n", regwr_n, 0);
        chk("sw_retired", Retired, 7);

        // ---- jal with a FETCH stall ----
        run_instr(32'h0000006F, 0, 0);
        chk("jal_cycles", ncyc, 5);
        chk("jal_irwr0", sn[0].ir_wr, 0);
        chk("jal_irwr1", sn[1].ir_wr, 1);
        chk("jal_st", sn[3].st, S_JAL);
        chk("jal_pcwr", sn[3].pc_wr, 1);
        chk("jal_src", {sn[3].src1, sn[3].src2}, 4'b0110);
        chk("jal_imm", sn[3].imm, 3'b100);

        // ---- jalr ----
        run_instr(32'h000080E7, -1, -1);
        chk("jalr_cycles", ncyc, 5);
        chk("jalr_st2", sn[2].st, S_JALR);
        chk("jalr_st3", sn[3].st, S_JAL);

        // ---- lui ----
        run_instr(32'h123450B7, -1, -1);
        chk("lui_cycles", ncyc, 4);
        chk("lui_src1", sn[2].src1, 2'b11);
        chk("lui_imm", sn[2].imm, 3'b011);
        chk("lui_retired", Retired, 10);

        // ---- illegal opcode ----
        run_instr(32'h0000007F, -1, -1);
        chk("ill_cycles", ncyc, 2);
        chk("ill_state", state_dbg, S_TRAP);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_hold_state", state_dbg, S_TRAP);
        chk("ill_illegal", Illegal, 1);
        chk("ill_strobes", {PC_Wr, IR_Wr, Reg_Wr, Mem_Wr, Mem_Rd}, 5'b0);
        do_reset();
        chk("ill_rst_state", state_dbg, S_FETCH);
        chk("ill_rst_illegal", Illegal, 0);
        chk("ill_rst_retired", Retired, 0);

        // ---- branch with reserved funct3 traps ----
        run_instr(32'h0020A463, -1, -1);
        chk("brtrap_cycles", ncyc, 3);
        chk("brtrap_pcwr", sn[2].pc_wr, 0);
        chk("brtrap_retire", sn[2].retire, 0);
        chk("brtrap_state", state_dbg, S_TRAP);
        do_reset();

        // ---- reset in the middle of a store ----
        Instruction = 32'h0020A023;
        Mem_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        Mem_Ready = 1'b0;
        #1;
        chk("midrst_memwr_before", Mem_Wr, 1);
        do_reset();
        chk("midrst_memwr_after", Mem_Wr, 0);
        chk("midrst_regwr_after", Reg_Wr, 0);
        chk("midrst_retired", Retired, 0);

        // ---- counter wrap: 16 back-to-back addi ----
        retire_total = 0;
        for (int i = 0; i < 16; i++) begin
            run_instr(32'h00108093, -1, -1);
            retire_total += pulses;
            chk("wrap_cnt", Retired, (i + 1) % 16);
        end
        chk("wrap_pulses", retire_total, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle RV32I control unit: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. It replaces the single-cycle decoder in the multi-cycle core, adds a memory-ready handshake, branch-condition flags, illegal-instruction trapping and a retired-instruction counter. Sits between the IR/flag outputs of the datapath and its mux/enable controls.

## Interface
- MEM_HANDSHAKE, 1: 1 = stall on Mem_Ready; 0 = Mem_Ready ignored, treated as 1.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- Instruction  in  32  current IR contents (valid from DECODE on).
- Zero, Lt, Ltu  in  1 each  ALU flags: result zero, signed less-than, unsigned less-than.
- Mem_Ready  in  1  memory completes the current access this cycle.
- PC_Wr, IR_Wr, Reg_Wr, Mem_Wr, Mem_Rd  out  1 each  enables/strobes.
- Adr_Src  out  1  0 = PC, 1 = ALUOut drives the memory address.
- ALU_Src1  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALU_Src2  out  2  00 rs2, 01 Immediate, 10 constant 4.
- Result_Src  out  2  00 ALUOut, 01 memory data, 10 ALU result (bypass).
- ALU_op  out  4  00 ADD, 1000 SUB, else {Funct7b5, Funct3}.
- Imm_Ctrl  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- dWidth_ctrl  out  3  load/store width (= Funct3 during memory states, 010 otherwise).
- Illegal  out  1  high while in TRAP.
- Retire  out  1  one-cycle pulse on instruction completion.
- Retired  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP.
- Unlisted outputs are 0 or don't-care mux selects; all strobes are 0 unless listed.
- FETCH: Adr_Src=0, Mem_Rd=1, ALU_Src1=00, ALU_Src2=10, ADD, Result_Src=10. When Mem_Ready: IR_Wr=1, PC_Wr=1, go to DECODE; otherwise hold.
- DECODE: ALU_Src1=01, ALU_Src2=01, ADD (branch/JAL target into ALUOut). Imm_Ctrl is decoded from the opcode and held valid from DECODE until the return to FETCH. Dispatch on opcode:
  - 0000011 → MEMADR (load)
  - 0100011 → MEMADR (store)
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 / 0010111 → UPPER
  - anything else → TRAP
- MEMADR: ALU_Src1=10, ALU_Src2=01, ADD. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: Adr_Src=1, Mem_Rd=1, dWidth_ctrl=Funct3. Go to MEMWB on Mem_Ready.
- MEMWB: Result_Src=01, Reg_Wr=1, dWidth_ctrl=Funct3, then FETCH.
- MEMWRITE: Adr_Src=1, Mem_Wr=1, dWidth_ctrl=Funct3. Hold until Mem_Ready, then FETCH.
- EXECR: ALU_Src1=10, ALU_Src2=00, ALU_op={Funct7b5,Funct3}, then ALUWB.
- EXECI: ALU_Src1=10, ALU_Src2=01, ALU_op={Funct3==101 ? Funct7b5 : 0, Funct3}, then ALUWB.
- ALUWB: Result_Src=00, Reg_Wr=1, then FETCH.
- BRANCH: ALU_Src1=10, ALU_Src2=00, SUB, Result_Src=00. PC_Wr is set when the branch is taken, then FETCH.
  - Taken conditions: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu.
  - Funct3 010 or 011 → TRAP instead, with PC_Wr=0.
- JAL: PC_Wr=1, Result_Src=00, ALU_Src1=01, ALU_Src2=10, ADD (link = OldPC+4), then ALUWB.
- JALR: ALU_Src1=10, ALU_Src2=01, ADD (target), then JAL state (reused for PC write + link).
  - The datapath clears bit 0 of the PC input.
  - JALR with Funct3 ≠ 000 → TRAP.
- UPPER: ALU_Src2=01, ADD; ALU_Src1=11 for LUI, 01 for AUIPC; then ALUWB.
- TRAP: Illegal=1, all strobes 0, stays until reset.
- Retirement: Retire=1 on the final cycle of each instruction, i.e. the cycle before FETCH re-entry:
  - MEMWB, ALUWB, BRANCH, and MEMWRITE with Mem_Ready.
  - Retired increments on the same edge and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (rst_n=0 at an edge): state=FETCH, Retired=0, Illegal=0. Strobes depend only on state, so after reset they are FETCH values (Mem_Rd=1; IR_Wr/PC_Wr=0 while Mem_Ready=0).
- Reset mid-instruction aborts it with no Reg_Wr/Mem_Wr on the following cycle.
- FETCH IR_Wr/PC_Wr and the MEMREAD/MEMWRITE exits are Mealy on Mem_Ready; all other outputs are Moore.
- Latency with zero wait states:
  - 3 cycles: branch
  - 4 cycles: R/I-type, U-type, store, JAL
  - 5 cycles: load, JALR
- Each cycle Mem_Ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.
- MEM_HANDSHAKE=0: single-cycle memory assumed.
- Mem_Wr is held high continuously until Mem_Ready; the write is committed once.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3), Mem_Ready=1 → states FETCH, DECODE, EXECR, ALUWB; ALU_op=0000; Reg_Wr only in cycle 4; Retired=1.
- `lw` (0x0000A183), Mem_Ready low 2 cycles in MEMREAD → 7 cycles total; Result_Src=01 and Reg_Wr in MEMWB; dWidth_ctrl=010.
- `bne` (0x00209463):
  - Zero=0 → PC_Wr=1 in BRANCH, ALU_op=1000.
  - Zero=1 → PC_Wr=0.
  - Both cases take 3 cycles.
- `srai` (0x4020D193) → ALU_op=1101. `sub` (0x402081B3) → ALU_op=1000.
- Opcode 0x0000007F → TRAP after DECODE, Illegal=1 and held; rst_n low one edge → FETCH, Illegal=0, Retired=0.
- CNT_W=4, 16 back-to-back `addi` instructions → Retired wraps to 0, with 16 Retire pulses.
